// File: rtl/pipe_sequencer.sv
// Pipeline sequencing controller for the decode stage.
// Arbitrates branch flushes, load-use stalls, two-word IADD immediate capture
// and HLT drain-then-freeze, and keeps a saturating load-use stall counter.
module pipe_sequencer #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             instr_valid,
    input  logic [6:0]       opcode,
    input  logic [2:0]       id_rs1,
    input  logic [2:0]       id_rs2,
    input  logic             id_uses_rs2,
    input  logic             ex_mem_read,
    input  logic [2:0]       ex_rd,
    input  logic             branch_taken,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             imm_capture,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [6:0] OP_HLT  = 7'b1100001;
    localparam logic [6:0] OP_IADD = 7'b0100000;
    localparam logic [6:0] OP_NOP  = 7'b1101000;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALT
    } state_t;

    state_t     state, next_state;
    logic [3:0] drain_cnt;
    logic       hazard;
    logic       drain_load;
    logic       stall_inc;

    // Unit-level outputs before reset gating
    logic pc_en_c, ifid_en_c, ifid_flush_c, idex_bubble_c, imm_capture_c, halted_c;

    // Load-use hazard: EX load writes a register the IF/ID instruction reads
    always_comb begin
        hazard = ex_mem_read && instr_valid &&
                 (opcode != OP_NOP) && (opcode != OP_HLT) &&
                 ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));
    end

    // Next-state and output decode, priority ordered within RUN
    always_comb begin
        next_state    = state;
        drain_load    = 1'b0;
        stall_inc     = 1'b0;
        pc_en_c       = 1'b0;
        ifid_en_c     = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_bubble_c = 1'b0;
        imm_capture_c = 1'b0;
        halted_c      = 1'b0;

        unique case (state)
            RUN: begin
                if (branch_taken) begin
                    pc_en_c       = 1'b1;
                    ifid_flush_c  = 1'b1;
                    idex_bubble_c = 1'b1;
                end else if (!instr_valid) begin
                    pc_en_c       = 1'b1;
                    ifid_en_c     = 1'b1;
                    idex_bubble_c = 1'b1;
                end else if (hazard) begin
                    idex_bubble_c = 1'b1;
                    stall_inc     = 1'b1;
                end else if (opcode == OP_HLT) begin
                    ifid_flush_c  = 1'b1;
                    drain_load    = 1'b1;
                    next_state    = DRAIN;
                end else if (opcode == OP_IADD) begin
                    // The word behind IADD is its immediate: capture it and
                    // flush the slot so it is never decoded as an instruction.
                    pc_en_c       = 1'b1;
                    imm_capture_c = 1'b1;
                    ifid_flush_c  = 1'b1;
                end else begin
                    pc_en_c       = 1'b1;
                    ifid_en_c     = 1'b1;
                end
            end
            DRAIN: begin
                ifid_flush_c  = 1'b1;
                idex_bubble_c = 1'b1;
                if (drain_cnt == 4'd0) begin
                    next_state = HALT;
                end
            end
            HALT: begin
                ifid_flush_c  = 1'b1;
                idex_bubble_c = 1'b1;
                halted_c      = 1'b1;
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    // Outputs are forced to the safe stall pattern while reset is held
    always_comb begin
        pc_en       = reset & pc_en_c;
        ifid_en     = reset & ifid_en_c;
        ifid_flush  = ~reset | ifid_flush_c;
        idex_bubble = ~reset | idex_bubble_c;
        imm_capture = reset & imm_capture_c;
        halted      = reset & halted_c;
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Drain counter: loaded when HLT issues, counts down while draining
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            drain_cnt <= '0;
        end else if (drain_load) begin
            drain_cnt <= DRAIN_LOAD;
        end else if ((state == DRAIN) && (drain_cnt != 4'd0)) begin
            drain_cnt <= drain_cnt - 4'd1;
        end
    end

    // Saturating load-use stall counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (stall_inc && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_sequencer.sv
// Self-checking bench for pipe_sequencer: two instances (default parameters,
// and CNT_W=4 / DRAIN_CYCLES=1) driven by the same directed vectors.
module tb_pipe_sequencer;

    localparam logic [6:0] OP_ADD  = 7'b0000000;
    localparam logic [6:0] OP_HLT  = 7'b1100001;
    localparam logic [6:0] OP_IADD = 7'b0100000;
    localparam logic [6:0] OP_NOP  = 7'b1101000;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [6:0] opcode;
    logic [2:0] id_rs1, id_rs2, ex_rd;
    logic       id_uses_rs2, ex_mem_read, branch_taken;

    logic        pc0, en0, fl0, bb0, im0, h0;
    logic        pc1, en1, fl1, bb1, im1, h1;
    logic [15:0] sc0;
    logic [3:0]  sc1;
    logic [5:0]  o0, o1;

    int checks = 0;
    int errors = 0;

    // Model state per instance: remaining drain cycles, halted flag, stall count
    int m_drain [2];
    bit m_halt  [2];
    int m_cnt   [2];
    int dcyc    [2] = '{3, 1};
    int cmax    [2] = '{65535, 15};

    always #5 clk = ~clk;

    pipe_sequencer #(.DRAIN_CYCLES(3), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .pc_en(pc0), .ifid_en(en0), .ifid_flush(fl0), .idex_bubble(bb0),
        .imm_capture(im0), .halted(h0), .stall_cnt(sc0)
    );

    pipe_sequencer #(.DRAIN_CYCLES(1), .CNT_W(4)) u1 (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .opcode(opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .branch_taken(branch_taken),
        .pc_en(pc1), .ifid_en(en1), .ifid_flush(fl1), .idex_bubble(bb1),
        .imm_capture(im1), .halted(h1), .stall_cnt(sc1)
    );

    // Output vector order: {pc_en, ifid_en, ifid_flush, idex_bubble, imm_capture, halted}
    assign o0 = {pc0, en0, fl0, bb0, im0, h0};
    assign o1 = {pc1, en1, fl1, bb1, im1, h1};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model compare: outputs mid-cycle against the rules, then advance the model
    always @(negedge clk) begin
        logic [5:0] e;
        int         ecnt;
        bit         hz;
        hz = ex_mem_read && instr_valid && opcode != OP_HLT && opcode != OP_NOP &&
             (ex_rd == id_rs1 || (id_uses_rs2 && ex_rd == id_rs2));
        for (int k = 0; k < 2; k++) begin
            ecnt = reset ? m_cnt[k] : 0;
            if (!reset) begin
                e = 6'b001100;
                m_drain[k] = 0; m_halt[k] = 1'b0; m_cnt[k] = 0;
            end else if (m_halt[k]) begin
                e = 6'b001101;
            end else if (m_drain[k] > 0) begin
                e = 6'b001100;
                m_drain[k]--;
                if (m_drain[k] == 0) m_halt[k] = 1'b1;
            end else if (branch_taken) begin
                e = 6'b101100;
            end else if (!instr_valid) begin
                e = 6'b110100;
            end else if (hz) begin
                e = 6'b000100;
                if (m_cnt[k] < cmax[k]) m_cnt[k]++;
            end else if (opcode == OP_HLT) begin
                e = 6'b001000;
                m_drain[k] = dcyc[k];
            end else if (opcode == OP_IADD) begin
                e = 6'b101010;
            end else begin
                e = 6'b110000;
            end
            chk($sformatf("model u%0d outputs", k), int'(k == 0 ? o0 : o1), int'(e));
            chk($sformatf("model u%0d stall_cnt", k), (k == 0) ? int'(sc0) : int'(sc1), ecnt);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic defaults();
        instr_valid = 1'b1; opcode = OP_ADD; id_rs1 = 3'd1; id_rs2 = 3'd2;
        id_uses_rs2 = 1'b1; ex_mem_read = 1'b0; ex_rd = 3'd0; branch_taken = 1'b0;
    endtask

    task automatic set_hazard_rs1();
        ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs1 = 3'd3;
    endtask

    initial begin
        reset = 1'b0;
        defaults();
        // Reset held with random inputs
        for (int i = 0; i < 3; i++) begin
            {instr_valid, opcode, id_rs1, id_rs2, id_uses_rs2, ex_mem_read, ex_rd, branch_taken} = 20'($urandom);
            @(negedge clk);
            chk("reset outputs", int'(o0), 'h0C);
            chk("reset stall_cnt", int'(sc0), 0);
            tick();
        end

        // Release, plain ADD
        reset = 1'b1;
        defaults();
        @(negedge clk);
        chk("add after reset", int'(o0), 'h30);
        tick();

        // Load-use on rs1
        set_hazard_rs1();
        @(negedge clk);
        chk("load-use rs1", int'(o0), 'h04);
        tick();
        defaults();
        @(negedge clk);
        chk("stall_cnt after one stall", int'(sc0), 1);
        tick();

        // rs2 match but rs2 unused: no stall
        ex_mem_read = 1'b1; ex_rd = 3'd3; id_rs2 = 3'd3; id_uses_rs2 = 1'b0;
        @(negedge clk);
        chk("rs2 unused no stall", int'(o0), 'h30);
        tick();

        // rs2 match and used: stall
        id_uses_rs2 = 1'b1;
        @(negedge clk);
        chk("load-use rs2", int'(o0), 'h04);
        tick();

        // Bubble in IF/ID with matching registers: no stall
        set_hazard_rs1(); instr_valid = 1'b0;
        @(negedge clk);
        chk("bubble no stall", int'(o0), 'h34);
        tick();

        // NOP with matching registers: no stall
        instr_valid = 1'b1; opcode = OP_NOP;
        @(negedge clk);
        chk("nop no stall", int'(o0), 'h30);
        tick();

        // IADD
        defaults(); opcode = OP_IADD;
        @(negedge clk);
        chk("iadd", int'(o0), 'h2A);
        tick();

        // Branch with hazard and HLT: flush wins
        set_hazard_rs1(); opcode = OP_HLT; branch_taken = 1'b1;
        @(negedge clk);
        chk("branch priority", int'(o0), 'h2C);
        tick();
        defaults();
        @(negedge clk);
        chk("branch no drain", int'(o0), 'h30);
        chk("branch no count", int'(sc0), 2);
        tick();

        // 20 back-to-back hazards: 4-bit counter saturates
        set_hazard_rs1();
        repeat (20) tick();
        defaults();
        @(negedge clk);
        chk("saturate u1", int'(sc1), 15);
        chk("count u0", int'(sc0), 22);
        tick();

        // HLT; branch_taken during drain must be ignored
        opcode = OP_HLT;
        @(negedge clk);
        chk("hlt issue", int'(o0), 'h08);
        tick();
        defaults(); branch_taken = 1'b1;
        @(negedge clk);
        chk("drain1 u0", int'(o0), 'h0C);
        chk("drain1 u1", int'(o1), 'h0C);
        tick();
        @(negedge clk);
        chk("drain2 u0", int'(o0), 'h0C);
        chk("halt u1", int'(o1), 'h0D);
        tick();
        @(negedge clk);
        chk("drain3 u0", int'(o0), 'h0C);
        tick();
        @(negedge clk);
        chk("halt u0", int'(o0), 'h0D);
        branch_taken = 1'b0;
        repeat (100) tick();
        @(negedge clk);
        chk("halt held u0", int'(h0), 1);
        tick();

        // Asynchronous reset pulse out of HALT
        reset = 1'b0;
        #1;
        chk("async reset halted u0", int'(h0), 0);
        chk("async reset halted u1", int'(h1), 0);
        chk("async reset outputs", int'(o0), 'h0C);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("run after reset", int'(o0), 'h30);
        chk("count cleared", int'(sc0), 0);
        tick();
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
